multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore FSM controller sequencing a multicycle RV32I datapath
//
// Purpose:
//   Steps each instruction through 3-5 cycles (FETCH, DECODE, then
//   instruction-specific states) and drives the datapath mux selects and
//   write enables. Supported: lw, sw, R-type, I-type ALU, beq, jal. Any
//   other opcode enters TRAP.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   op          in   Instr[6:0] from IR
//   funct3      in   Instr[14:12]
//   funct7b5    in   Instr[30]
//   Zero        in   ALU zero flag
//   PCWrite     out  PC register enable
//   AdrSrc      out  memory address select: 0=PC, 1=Result
//   MemWrite    out  memory write enable
//   IRWrite     out  IR and OldPC enable
//   ResultSrc   out  00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA     out  00=PC, 01=OldPC, 10=A
//   ALUSrcB     out  00=B, 01=ImmExt, 10=const 4
//   ImmSrc      out  00=I, 01=S, 10=B, 11=J
//   ALUControl  out  000 add, 001 sub, 010 and, 011 or, 101 slt
//   RegWrite    out  register file write enable
//   instr_done  out  one-cycle pulse in the final state of each instruction
//   trap        out  high while in TRAP

module multicycle_ctrl #(
    parameter bit TRAP_HOLD = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       trap
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t r_state;
    state_t w_next_state;

    // Raw per-state decode; every output is gated by reset_n below so that
    // the FETCH outputs of the reset state never leak while reset is held.
    logic       w_pc_update;
    logic       w_branch;
    logic [1:0] w_alu_op;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic       w_reg_write;
    logic       w_instr_done;
    logic       w_trap;
    logic [1:0] w_imm_src;
    logic [2:0] w_alu_control;
    logic       w_pc_write;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  w_next_state = S_MEMADR;
                    OP_RTYPE:  w_next_state = S_EXECR;
                    OP_ITYPE:  w_next_state = S_EXECI;
                    OP_BRANCH: w_next_state = S_BEQ;
                    OP_JAL:    w_next_state = S_JAL;
                    default:   w_next_state = S_TRAP;
                endcase
            end
            // op[5] separates stores (0100011) from loads (0000011)
            S_MEMADR:   w_next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = S_FETCH;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            // JAL writes rd = PC+4 through the shared ALUWB state
            S_JAL:      w_next_state = S_ALUWB;
            S_TRAP:     w_next_state = TRAP_HOLD ? S_TRAP : S_FETCH;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Moore outputs per state
    always_comb begin
        w_pc_update   = 1'b0;
        w_branch      = 1'b0;
        w_alu_op      = 2'b00;
        w_adr_src     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_reg_write   = 1'b0;
        w_instr_done  = 1'b0;
        w_trap        = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_alu_src_a  = 2'b00;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_pc_update  = 1'b1;
            end
            S_DECODE: begin
                // Branch target OldPC + imm is precomputed here into ALUOut
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_result_src = 2'b00;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_EXECR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b00;
                w_alu_op    = 2'b10;
            end
            S_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
            end
            S_ALUWB: begin
                w_result_src = 2'b00;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BEQ: begin
                // ResultSrc=00 routes the DECODE-computed target to the PC
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b00;
                w_alu_op     = 2'b01;
                w_result_src = 2'b00;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
            end
            S_JAL: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b00;
                w_pc_update  = 1'b1;
            end
            S_TRAP: begin
                w_trap = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Immediate format follows the opcode directly, independent of state
    always_comb begin
        w_imm_src = 2'b00;
        case (op)
            OP_LOAD,
            OP_ITYPE:  w_imm_src = 2'b00;
            OP_STORE:  w_imm_src = 2'b01;
            OP_BRANCH: w_imm_src = 2'b10;
            OP_JAL:    w_imm_src = 2'b11;
            default:   w_imm_src = 2'b00;
        endcase
    end

    // ALU decoder; sub needs op[5] so that addi with Instr[30]=1 stays add
    always_comb begin
        w_alu_control = 3'b000;
        case (w_alu_op)
            2'b00: w_alu_control = 3'b000;
            2'b01: w_alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  w_alu_control = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b010:  w_alu_control = 3'b101;
                    3'b110:  w_alu_control = 3'b011;
                    3'b111:  w_alu_control = 3'b010;
                    default: w_alu_control = 3'b000;
                endcase
            end
            default: w_alu_control = 3'b000;
        endcase
    end

    // Only Mealy term: the branch is taken combinationally on Zero
    assign w_pc_write = (w_branch & Zero) | w_pc_update;

    assign PCWrite    = reset_n & w_pc_write;
    assign AdrSrc     = reset_n & w_adr_src;
    assign MemWrite   = reset_n & w_mem_write;
    assign IRWrite    = reset_n & w_ir_write;
    assign ResultSrc  = reset_n ? w_result_src  : 2'b00;
    assign ALUSrcA    = reset_n ? w_alu_src_a   : 2'b00;
    assign ALUSrcB    = reset_n ? w_alu_src_b   : 2'b00;
    assign ImmSrc     = reset_n ? w_imm_src     : 2'b00;
    assign ALUControl = reset_n ? w_alu_control : 3'b000;
    assign RegWrite   = reset_n & w_reg_write;
    assign instr_done = reset_n & w_instr_done;
    assign trap       = reset_n & w_trap;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl

module tb_multicycle_ctrl;

    logic       clk;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       RegWrite;
    logic       instr_done;
    logic       trap;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl #(.TRAP_HOLD(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .trap       (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,RegWrite,instr_done,trap}
    function automatic logic [17:0] outs();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, ALUControl, RegWrite, instr_done, trap};
    endfunction

    function automatic logic [17:0] v(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] imm, input logic [2:0] aluc,
                                      input logic rw, input logic dn, input logic tp);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, aluc, rw, dn, tp};
    endfunction

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%05h expected=%05h", tag, got, exp);
        end
    endtask

    task automatic set_instr(input logic [31:0] w);
        op       = w[6:0];
        funct3   = w[14:12];
        funct7b5 = w[30];
    endtask

    // Sample on the falling edge, then advance past the next rising edge
    task automatic step(input string tag, input logic [17:0] exp);
        @(negedge clk);
        check(tag, outs(), exp);
        @(posedge clk);
        #1;
    endtask

    // FETCH and DECODE vectors for a given ImmSrc
    function automatic logic [17:0] v_fetch(input logic [1:0] imm);
        return v(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0, 0);
    endfunction
    function automatic logic [17:0] v_decode(input logic [1:0] imm);
        return v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 0, 0);
    endfunction

    task automatic run_r(input string tag, input logic [31:0] w, input logic [2:0] aluc);
        set_instr(w);
        step({tag, "_fetch"},  v_fetch(2'b00));
        step({tag, "_decode"}, v_decode(2'b00));
        step({tag, "_execr"},  v(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, aluc, 0, 0, 0));
        step({tag, "_aluwb"},  v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0));
    endtask

    task automatic run_lw_to_memadr(input string tag);
        set_instr(32'h00802283);
        step({tag, "_fetch"},  v_fetch(2'b00));
        step({tag, "_decode"}, v_decode(2'b00));
        step({tag, "_memadr"}, v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0, 0));
    endtask

    initial begin
        reset_n = 1'b0;
        Zero    = 1'b0;
        set_instr(32'h00802283);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", outs(), 18'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // lw: 5 cycles
        run_lw_to_memadr("lw");
        step("lw_memread", v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0));
        step("lw_memwb",   v(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0));

        // sw: 4 cycles, ImmSrc=01 throughout
        set_instr(32'h0051A423);
        step("sw_fetch",    v_fetch(2'b01));
        step("sw_decode",   v_decode(2'b01));
        step("sw_memadr",   v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0, 0));
        step("sw_memwrite", v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 1, 0));

        // R-type ALU decode
        run_r("sub",  32'h40B50533, 3'b001);
        run_r("add",  32'h00B50533, 3'b000);
        run_r("or",   32'h00B56533, 3'b011);
        run_r("and",  32'h00B57533, 3'b010);
        run_r("slt",  32'h00B52533, 3'b101);
        run_r("sll",  32'h00B51533, 3'b000);

        // addi with Instr[30]=1 stays add
        set_instr(32'h40050513);
        step("addi_fetch",  v_fetch(2'b00));
        step("addi_decode", v_decode(2'b00));
        step("addi_execi",  v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0, 0));
        step("addi_aluwb",  v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0));

        // beq taken / not taken: 3 cycles
        set_instr(32'h00628463);
        Zero = 1'b1;
        step("beqt_fetch",  v_fetch(2'b10));
        step("beqt_decode", v_decode(2'b10));
        step("beqt_beq",    v(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 1, 0));
        Zero = 1'b0;
        step("beqn_fetch",  v_fetch(2'b10));
        step("beqn_decode", v_decode(2'b10));
        step("beqn_beq",    v(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 1, 0));

        // jal: 4 cycles
        set_instr(32'h008000EF);
        step("jal_fetch",  v_fetch(2'b11));
        step("jal_decode", v_decode(2'b11));
        step("jal_jal",    v(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0, 0));
        step("jal_aluwb",  v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1, 1, 0));

        // illegal opcode: trap from cycle 2, sticky
        set_instr(32'h0000007F);
        step("ill_fetch",  v_fetch(2'b00));
        step("ill_decode", v_decode(2'b00));
        for (int i = 0; i < 10; i++) begin
            step($sformatf("ill_trap%0d", i), v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 1));
        end

        // reset out of TRAP
        reset_n = 1'b0;
        #1;
        check("trap_rst_async", outs(), 18'h0);
        set_instr(32'h00802283);
        step("trap_rst_held", 18'h0);
        reset_n = 1'b1;

        // lw aborted by reset mid-MEMREAD
        run_lw_to_memadr("lwa");
        #1;
        check("lwa_memread", outs(), v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0));
        reset_n = 1'b0;
        #1;
        check("lwa_rst_async", outs(), 18'h0);
        step("lwa_rst_held", 18'h0);
        reset_n = 1'b1;
        run_lw_to_memadr("lwb");
        step("lwb_memread", v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0));
        step("lwb_memwb",   v(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
